id_ex_skid_reg: RTL and testbench
=================================

Name: id_ex_skid_reg

Overview:
- Parametrised decode-to-execute pipeline register, successor to the fixed single-entry ID/EX latch.
- Adds a valid/ready handshake with a 2-entry skid buffer, so execute-side backpressure never drops an instruction.
- Flush inserts a bubble and clears both entries.
- Built-in load-use hazard stall and a saturating stall-cycle counter.
- Sits between the decode logic (control unit, register file, sign extender) and the execute stage.

Parameters:
- XLEN, 32, width of RD1/RD2/PC/ImmExt/PCPlus4.
- RA_W, 5, register index width.
- ALUCTRL_W, 3, ALUControl width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill all held entries (branch/jump taken).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  block accepts this cycle.
- in_ctrl  in  CTRL_W  {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl, ALUSrc}.
- in_rd1, in_rd2, in_pc, in_imm, in_pcplus4  in  XLEN each  decode data.
- in_rs1, in_rs2, in_rd  in  RA_W each  register indices.
- out_valid  out  1  execute-side entry valid.
- out_ready  in  1  execute consumes this cycle.
- out_ctrl  out  CTRL_W  control of head entry; all zero when !out_valid.
- out_rd1, out_rd2, out_pc, out_imm, out_pcplus4  out  XLEN each  head entry data.
- out_rs1, out_rs2, out_rd  out  RA_W each  head entry indices (feed forwarding unit).
- hazard_stall  out  1  load-use stall active this cycle.
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid & !in_ready.

Behaviour:
- Storage: head register (drives outputs) and skid register, one valid bit each. State encoded EMPTY / ONE / TWO.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- out_valid = (state != EMPTY).
- in_ready = (state != TWO) & !hazard_stall. The TWO term is registered; the hazard term is combinational.
- Transitions (when no flush):
  - EMPTY: accept -> ONE, head <= in.
  - ONE: accept & !pop -> TWO, skid <= in. accept & pop -> ONE, head <= in. pop & !accept -> EMPTY.
  - TWO: pop -> ONE, head <= skid. No accept is possible in TWO.
- Flush:
  - Highest priority over accept and pop; next state is EMPTY.
  - An input presented in the same cycle is discarded.
  - Data fields need not clear; only the valid bits clear.
- Bubble: out_ctrl is forced to 0 whenever !out_valid, so RegWrite, MemWrite, Branch and Jump are never asserted by a bubble.
- hazard_stall is asserted when all of the following hold:
  - out_valid
  - head ResultSrc == 2'b01 (load)
  - head rd != 0
  - in_valid
  - in_rs1 == head rd, or in_rs2 == head rd
- hazard_stall is combinational. It releases automatically once the load pops.
- stall_cnt increments when in_valid & !in_ready and flush is low. It saturates at all-ones and never wraps.
- Reset (asynchronous, rst=1):
  - state EMPTY, all valid bits 0.
  - All data and control registers 0.
  - stall_cnt 0.
  - Therefore out_valid=0, out_ctrl=0, all outputs 0, and in_ready=1.
- Reset mid-operation drops all held entries immediately, with no pending handshake.
- Latency: 1 cycle from accept to out_valid when empty or when popping the same cycle. Full throughput is 1 instruction per cycle when out_ready is held high.
- Ordering is strictly FIFO: the skid entry never overtakes the head entry.

Decomposition:
- Shared package pipe_pkg holds:
  - ctrl_t packed struct (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc) and CTRL_W.
  - RESULTSRC_LOAD = 2'b01.
  - skid_state_t enum (EMPTY, ONE, TWO).
- One sub-module is natural: skid_entry, a payload register with enable and valid bit, instantiated twice (head and skid).
- The hazard comparator stays inline.

Test Plan:
- Reset: rst=1 for 3 cycles while in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0. After release, first accept of pc=0x0000_0004 appears on out_pc the next cycle.
- Backpressure: out_ready=0, push pc=0x10 then 0x14 -> in_ready=0 after the second push (TWO). Raise out_ready -> out_pc reads 0x10 then 0x14 on consecutive cycles; third push 0x18 follows with no loss and no duplication.
- Flush: state TWO, flush=1 with in_valid=1 pc=0x20 -> next cycle out_valid=0, out_ctrl=0, state EMPTY; pc=0x20 never emerges.
- Load-use: head holds a load (ResultSrc=01, rd=5); decode presents rs1=5 -> hazard_stall=1, in_ready=0, stall_cnt increments by 1. Pop the head -> hazard_stall=0 and the instruction is accepted.
- x0 exemption: head load with rd=0 and in_rs2=0 -> hazard_stall=0, accepted in the same cycle.
- Counter saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt=4'hF, with no wrap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the decode-to-execute boundary: control bundle layout,
// the load encoding of ResultSrc, and the skid buffer occupancy states.
package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/skid_entry.sv
// One storage slot of the skid buffer: a payload register loaded on enable
// plus its valid bit, both cleared by the asynchronous reset.
module skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_we,
  input  logic         i_vld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_vld
);

  logic [W-1:0] r_q;
  logic         r_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= i_vld;
      if (i_we) r_q <= i_d;
    end
  end

  assign o_q   = r_q;
  assign o_vld = r_vld;

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a two-entry skid buffer, flush-to-bubble,
// load-use hazard stall and a saturating stall-cycle counter.
module id_ex_skid_reg
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CTRL_W-3+ALUCTRL_W-1:0]   in_ctrl,
  input  logic [XLEN-1:0]                 in_rd1,
  input  logic [XLEN-1:0]                 in_rd2,
  input  logic [XLEN-1:0]                 in_pc,
  input  logic [XLEN-1:0]                 in_imm,
  input  logic [XLEN-1:0]                 in_pcplus4,
  input  logic [RA_W-1:0]                 in_rs1,
  input  logic [RA_W-1:0]                 in_rs2,
  input  logic [RA_W-1:0]                 in_rd,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CTRL_W-3+ALUCTRL_W-1:0]   out_ctrl,
  output logic [XLEN-1:0]                 out_rd1,
  output logic [XLEN-1:0]                 out_rd2,
  output logic [XLEN-1:0]                 out_pc,
  output logic [XLEN-1:0]                 out_imm,
  output logic [XLEN-1:0]                 out_pcplus4,
  output logic [RA_W-1:0]                 out_rs1,
  output logic [RA_W-1:0]                 out_rs2,
  output logic [RA_W-1:0]                 out_rd,
  output logic                            hazard_stall,
  output logic [CNT_W-1:0]                stall_cnt
);

  localparam int W_CTRL = CTRL_W - 3 + ALUCTRL_W;
  localparam int PAY_W  = W_CTRL + 5 * XLEN + 3 * RA_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [PAY_W-1:0]  w_in_pay;
  logic [PAY_W-1:0]  w_head_d;
  logic [PAY_W-1:0]  w_head_q;
  logic [PAY_W-1:0]  w_skid_q;
  logic              w_head_vld;
  logic              w_skid_vld;
  logic              w_head_we;
  logic              w_skid_we;
  logic              w_head_from_skid;
  logic              w_accept;
  logic              w_pop;
  logic              w_hazard;
  logic [W_CTRL-1:0] w_head_ctrl;

  assign w_in_pay = {in_ctrl, in_rd1, in_rd2, in_pc, in_imm, in_pcplus4,
                     in_rs1, in_rs2, in_rd};

  assign {w_head_ctrl, out_rd1, out_rd2, out_pc, out_imm, out_pcplus4,
          out_rs1, out_rs2, out_rd} = w_head_q;

  // Load-use: the instruction in decode reads the register a load in the
  // head slot has not produced yet; x0 never carries a dependency.
  assign w_hazard = w_head_vld
                  & (w_head_ctrl[W_CTRL-2 -: 2] == RESULTSRC_LOAD)
                  & (out_rd != '0)
                  & in_valid
                  & ((in_rs1 == out_rd) | (in_rs2 == out_rd));

  assign hazard_stall = w_hazard;
  assign in_ready     = ~w_skid_vld & ~w_hazard;
  assign out_valid    = w_head_vld;
  assign out_ctrl     = w_head_vld ? w_head_ctrl : '0;
  assign stall_cnt    = r_stall_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_pop    = w_head_vld & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_head_we        = 1'b0;
    w_skid_we        = 1'b0;
    w_head_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_head_we   = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_accept && !w_pop) begin
            w_skid_we   = 1'b1;
            w_state_nxt = TWO;
          end else if (w_accept && w_pop) begin
            w_head_we   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_head_we        = 1'b1;
            w_head_from_skid = 1'b1;
            w_state_nxt      = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  assign w_head_d = w_head_from_skid ? w_skid_q : w_in_pay;

  skid_entry #(.W(PAY_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .i_we  (w_head_we),
    .i_vld (w_state_nxt != EMPTY),
    .i_d   (w_head_d),
    .o_q   (w_head_q),
    .o_vld (w_head_vld)
  );

  skid_entry #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .i_we  (w_skid_we),
    .i_vld (w_state_nxt == TWO),
    .i_d   (w_in_pay),
    .o_q   (w_skid_q),
    .o_vld (w_skid_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (in_valid && !in_ready && !flush) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed bench for id_ex_skid_reg: reset, backpressure, flush, load-use,
// x0 exemption, streaming throughput and stall counter saturation.
module tb_id_ex_skid_reg;

  localparam logic [9:0] OP = 10'h204;  // R-type: RegWrite, ALUControl=010
  localparam logic [9:0] LD = 10'h281;  // load: RegWrite, ResultSrc=01, ALUSrc

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, hazard_stall;
  logic [9:0]  in_ctrl, out_ctrl;
  logic [31:0] in_rd1, in_rd2, in_pc, in_imm, in_pcplus4;
  logic [31:0] out_rd1, out_rd2, out_pc, out_imm, out_pcplus4;
  logic [4:0]  in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic [3:0]  stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_cnt;

  always #5 clk = ~clk;

  id_ex_skid_reg #(.XLEN(32), .RA_W(5), .ALUCTRL_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pcplus4(in_pcplus4), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_pc(out_pc), .out_imm(out_imm),
    .out_pcplus4(out_pcplus4), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [9:0] c,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    in_valid   = v;
    in_pc      = pc;
    in_rd1     = pc ^ 32'hA5A5_0000;
    in_rd2     = pc + 32'h100;
    in_imm     = pc << 1;
    in_pcplus4 = pc + 32'd4;
    in_ctrl    = c;
    in_rs1     = s1;
    in_rs2     = s2;
    in_rd      = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'h4, OP, 5'd1, 5'd2, 5'd3);
    repeat (3) tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_ctrl !== 10'h0) begin bad++; $display("FAIL reset_out_ctrl got=%h exp=000", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (stall_cnt !== 4'h0) begin bad++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    rst = 1'b0;
    tick;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL first_pc got=%h exp=00000004", out_pc); end
    total++; if (out_ctrl !== OP) begin bad++; $display("FAIL first_ctrl got=%h exp=%h", out_ctrl, OP); end
    total++; if (out_rd1 !== 32'hA5A5_0004) begin bad++; $display("FAIL first_rd1 got=%h exp=a5a50004", out_rd1); end
    drive(1'b0, 32'h0, OP, 5'd0, 5'd0, 5'd0);
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    total++; if (out_ctrl !== 10'h0) begin bad++; $display("FAIL bubble_ctrl got=%h exp=000", out_ctrl); end
    exp_cnt = 4'h0;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(1'b1, 32'h10, OP, 5'd1, 5'd2, 5'd3);
    tick;
    total++; if (out_pc !== 32'h10) begin bad++; $display("FAIL bp_head got=%h exp=00000010", out_pc); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
    drive(1'b1, 32'h14, OP, 5'd1, 5'd2, 5'd3);
    tick;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_two got=%b exp=0", in_ready); end
    total++; if (out_pc !== 32'h10) begin bad++; $display("FAIL bp_head_hold got=%h exp=00000010", out_pc); end
    drive(1'b1, 32'h18, OP, 5'd1, 5'd2, 5'd3);
    out_ready = 1'b1;
    tick;
    exp_cnt = exp_cnt + 4'd1;
    total++; if (out_pc !== 32'h14) begin bad++; $display("FAIL bp_second got=%h exp=00000014", out_pc); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL bp_stall_cnt got=%h exp=%h", stall_cnt, exp_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b exp=1", in_ready); end
    tick;
    total++; if (out_pc !== 32'h18) begin bad++; $display("FAIL bp_third got=%h exp=00000018", out_pc); end
    drive(1'b0, 32'h0, OP, 5'd0, 5'd0, 5'd0);
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 32'h30, OP, 5'd1, 5'd2, 5'd3);
    tick;
    drive(1'b1, 32'h34, OP, 5'd1, 5'd2, 5'd3);
    tick;
    drive(1'b1, 32'h20, OP, 5'd1, 5'd2, 5'd3);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    total++; if (out_ctrl !== 10'h0) begin bad++; $display("FAIL flush_ctrl got=%h exp=000", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL flush_stall_cnt got=%h exp=%h", stall_cnt, exp_cnt); end
    drive(1'b0, 32'h0, OP, 5'd0, 5'd0, 5'd0);
    out_ready = 1'b1;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard got=%b exp=0", out_valid); end
    drive(1'b1, 32'h40, OP, 5'd1, 5'd2, 5'd3);
    tick;
    total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL flush_recover got=%h exp=00000040", out_pc); end
    drive(1'b0, 32'h0, OP, 5'd0, 5'd0, 5'd0);
    tick;
  endtask

  task automatic test_load_use;
    out_ready = 1'b0;
    drive(1'b1, 32'h50, LD, 5'd1, 5'd2, 5'd5);
    tick;
    total++; if (out_ctrl !== LD) begin bad++; $display("FAIL lu_head_ctrl got=%h exp=%h", out_ctrl, LD); end
    drive(1'b1, 32'h54, OP, 5'd5, 5'd0, 5'd6);
    #1;
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_hazard_rs1 got=%b exp=1", hazard_stall); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_ready got=%b exp=0", in_ready); end
    drive(1'b1, 32'h54, OP, 5'd9, 5'd5, 5'd6);
    #1;
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_hazard_rs2 got=%b exp=1", hazard_stall); end
    drive(1'b1, 32'h54, OP, 5'd9, 5'd9, 5'd6);
    #1;
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_no_match got=%b exp=0", hazard_stall); end
    drive(1'b1, 32'h54, OP, 5'd5, 5'd0, 5'd6);
    #1;
    tick;
    exp_cnt = exp_cnt + 4'd1;
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL lu_stall_cnt got=%h exp=%h", stall_cnt, exp_cnt); end
    total++; if (out_pc !== 32'h50) begin bad++; $display("FAIL lu_head_hold got=%h exp=00000050", out_pc); end
    out_ready = 1'b1;
    tick;
    exp_cnt = exp_cnt + 4'd1;
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", hazard_stall); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_ready_release got=%b exp=1", in_ready); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL lu_stall_cnt2 got=%h exp=%h", stall_cnt, exp_cnt); end
    tick;
    total++; if (out_pc !== 32'h54) begin bad++; $display("FAIL lu_accepted got=%h exp=00000054", out_pc); end
    drive(1'b0, 32'h0, OP, 5'd0, 5'd0, 5'd0);
    tick;
  endtask

  task automatic test_x0;
    out_ready = 1'b0;
    drive(1'b1, 32'h60, LD, 5'd1, 5'd2, 5'd0);
    tick;
    drive(1'b1, 32'h64, OP, 5'd1, 5'd0, 5'd7);
    #1;
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL x0_hazard got=%b exp=0", hazard_stall); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    tick;
    total++; if (out_pc !== 32'h64) begin bad++; $display("FAIL x0_accepted got=%h exp=00000064", out_pc); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL x0_stall_cnt got=%h exp=%h", stall_cnt, exp_cnt); end
    drive(1'b0, 32'h0, OP, 5'd0, 5'd0, 5'd0);
    tick;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), OP, 5'd1, 5'd2, 5'd3);
      tick;
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i)) begin
        bad++;
        $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, out_valid, out_pc, 32'h100 + 32'(4 * i));
      end
    end
    drive(1'b0, 32'h0, OP, 5'd0, 5'd0, 5'd0);
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_stall_cnt got=%h exp=%h", stall_cnt, exp_cnt); end
  endtask

  task automatic test_saturation;
    out_ready = 1'b0;
    drive(1'b1, 32'h70, OP, 5'd1, 5'd2, 5'd3);
    tick;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    total++; if (stall_cnt !== 4'h0) begin bad++; $display("FAIL arst_cnt got=%h exp=0", stall_cnt); end
    rst = 1'b0;
    drive(1'b1, 32'h80, OP, 5'd1, 5'd2, 5'd3);
    tick;
    drive(1'b1, 32'h84, OP, 5'd1, 5'd2, 5'd3);
    tick;
    drive(1'b1, 32'h88, OP, 5'd1, 5'd2, 5'd3);
    repeat (14) tick;
    total++; if (stall_cnt !== 4'hE) begin bad++; $display("FAIL sat_mid got=%h exp=e", stall_cnt); end
    repeat (6) tick;
    total++; if (stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_top got=%h exp=f", stall_cnt); end
    tick;
    total++; if (stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_nowrap got=%h exp=f", stall_cnt); end
    total++; if (out_pc !== 32'h80) begin bad++; $display("FAIL sat_head got=%h exp=00000080", out_pc); end
    drive(1'b0, 32'h0, OP, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_backpressure;
    test_flush;
    test_load_use;
    test_x0;
    test_back_to_back;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
